// File: rtl/io_periph_bank_if.sv
// Request/response bus between the core LSU I/O window and the peripheral bank.
// The master drives req_*, the bank answers on rsp_* one cycle later.
interface io_periph_bank_if;
    logic        req_valid_i;
    logic        req_we_i;
    logic [11:0] req_addr_i;
    logic [3:0]  req_be_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_be_i, req_wdata_i,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_be_i, req_wdata_i,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/io_periph_bank.sv
// Memory-mapped I/O bank: LED/LCD/hex output registers plus synchronised,
// debounced switches with rising-edge capture and a maskable interrupt.
module io_periph_bank #(
    parameter int NUM_HEX      = 8,
    parameter int SW_W         = 32,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    io_periph_bank_if.slave       bus,
    input  logic [SW_W-1:0]       io_sw_i,
    output logic [31:0]           io_ledr_o,
    output logic [31:0]           io_ledg_o,
    output logic [31:0]           io_lcd_o,
    output logic [32*NUM_HEX-1:0] io_hex_o,
    output logic                  sw_irq_o
);
    localparam int            CW      = $clog2(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] CNT_ACC = CW'(DEBOUNCE_CYC - 2);

    logic [9:0]         widx;
    logic [31:0]        bmask;
    logic               hit_ledr, hit_ledg, hit_lcd, hit_sw, hit_edge, hit_irq;
    logic [NUM_HEX-1:0] hit_hex;
    logic               mapped, err, wr_ok;
    logic [31:0]        rd_data, clr_w, irq_w;

    logic [31:0]        hex_q [NUM_HEX];
    logic [31:0]        ledr_q, ledg_q, lcd_q;
    logic [SW_W-1:0]    sw_m, sw_s, cand, sw_db, sw_db_d, edge_cap, irq_en;
    logic [SW_W-1:0]    rise, clr, irq_en_nxt;
    logic [CW-1:0]      cnt;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [31:0] m);
        return (old & ~m) | (wd & m);
    endfunction

    assign widx  = bus.req_addr_i[11:2];
    assign bmask = {{8{bus.req_be_i[3]}}, {8{bus.req_be_i[2]}},
                    {8{bus.req_be_i[1]}}, {8{bus.req_be_i[0]}}};

    always_comb begin
        hit_ledr = (widx == 10'h000);
        hit_ledg = (widx == 10'h004);
        hit_lcd  = (widx == 10'h028);
        hit_sw   = (widx == 10'h040);
        hit_edge = (widx == 10'h041);
        hit_irq  = (widx == 10'h042);
        for (int i = 0; i < NUM_HEX; i++) hit_hex[i] = (widx == 10'(8 + i));
        mapped = hit_ledr | hit_ledg | hit_lcd | hit_sw | hit_edge | hit_irq | (|hit_hex);
        // SW_DB is read-only: a write there is reported and has no effect
        err   = !mapped || (bus.req_we_i && hit_sw);
        wr_ok = bus.req_valid_i && bus.req_we_i && !err;
        rd_data = '0;
        if (!bus.req_we_i) begin
            if (hit_ledr) rd_data = ledr_q;
            if (hit_ledg) rd_data = ledg_q;
            if (hit_lcd)  rd_data = lcd_q;
            if (hit_sw)   rd_data = 32'(sw_db);
            if (hit_edge) rd_data = 32'(edge_cap);
            if (hit_irq)  rd_data = 32'(irq_en);
            for (int i = 0; i < NUM_HEX; i++) if (hit_hex[i]) rd_data = hex_q[i];
        end
    end

    always_comb begin
        clr_w      = (wr_ok && hit_edge) ? (bus.req_wdata_i & bmask) : '0;
        clr        = clr_w[SW_W-1:0];
        irq_w      = merge(32'(irq_en), bus.req_wdata_i, bmask);
        irq_en_nxt = irq_w[SW_W-1:0];
        rise       = sw_db & ~sw_db_d;
    end

    for (genvar i = 0; i < NUM_HEX; i++) begin : g_hex
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)                     hex_q[i] <= '0;
            else if (wr_ok && hit_hex[i]) hex_q[i] <= merge(hex_q[i], bus.req_wdata_i, bmask);
        end
        assign io_hex_o[32*i +: 32] = hex_q[i];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ledr_q <= '0;
            ledg_q <= '0;
            lcd_q  <= '0;
            bus.rsp_valid_o <= 1'b0;
            bus.rsp_rdata_o <= '0;
            bus.rsp_err_o   <= 1'b0;
        end else begin
            if (wr_ok && hit_ledr) ledr_q <= merge(ledr_q, bus.req_wdata_i, bmask);
            if (wr_ok && hit_ledg) ledg_q <= merge(ledg_q, bus.req_wdata_i, bmask);
            if (wr_ok && hit_lcd)  lcd_q  <= merge(lcd_q,  bus.req_wdata_i, bmask);
            bus.rsp_valid_o <= bus.req_valid_i;
            bus.rsp_rdata_o <= bus.req_valid_i ? rd_data : '0;
            bus.rsp_err_o   <= bus.req_valid_i && err;
        end
    end

    // Debounce is vector-wide: any change on any bit restarts the stability window.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sw_m     <= '0;
            sw_s     <= '0;
            cand     <= '0;
            cnt      <= '0;
            sw_db    <= '0;
            sw_db_d  <= '0;
            edge_cap <= '0;
            irq_en   <= '0;
            sw_irq_o <= 1'b0;
        end else begin
            sw_m    <= io_sw_i;
            sw_s    <= sw_m;
            sw_db_d <= sw_db;
            if (sw_s != cand) begin
                cand <= sw_s;
                cnt  <= '0;
            end else begin
                if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                if (cnt >= CNT_ACC) sw_db <= cand;
            end
            // a fresh rising edge outranks a simultaneous W1C on the same bit
            edge_cap <= (edge_cap & ~clr) | rise;
            if (wr_ok && hit_irq) irq_en <= irq_en_nxt;
            sw_irq_o <= |(edge_cap & irq_en);
        end
    end

    assign io_ledr_o = ledr_q;
    assign io_ledg_o = ledg_q;
    assign io_lcd_o  = lcd_q;
endmodule
